// File: rtl/vgpr_rd_arb_pkg.sv
// Shared constants for the VGPR N-to-1 read-port arbiter.
//   ARB_RR / ARB_FIXED : arbitration mode selectors
//   DEF_*              : default widths and depths
//   port_idx_w()       : requester index width, never narrower than 1 bit
package vgpr_rd_arb_pkg;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    localparam int DEF_NUM_PORTS  = 2;
    localparam int DEF_ADDRWIDTH  = 10;
    localparam int DEF_DATAWIDTH  = 2048;
    localparam int DEF_RD_LATENCY = 1;

    function automatic int port_idx_w(input int num_ports);
        return (num_ports <= 1) ? 1 : $clog2(num_ports);
    endfunction

endpackage

// File: rtl/vgpr_rr_arbiter.sv
// Request vector to one-hot grant arbiter, round-robin or fixed priority.
//   clk, rst    : clock, synchronous active-high reset
//   req         : per-requester request
//   grant       : one-hot grant (zero while in reset)
//   grant_idx   : encoded index of the granted requester
//   grant_valid : a grant was issued this cycle
module vgpr_rr_arbiter
    import vgpr_rd_arb_pkg::*;
#(
    parameter int NUM_PORTS = DEF_NUM_PORTS,
    parameter int ARB_MODE  = ARB_RR,
    localparam int IDX_W    = port_idx_w(NUM_PORTS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req,
    output logic [NUM_PORTS-1:0] grant,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 grant_valid
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    int               base;
    int               pos;

    // Walk requesters starting at the search base; the inner loop keeps
    // every bit select constant after unrolling.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        base        = (ARB_MODE == ARB_FIXED) ? 0 : int'(ptr_q);
        pos         = 0;
        if (!rst) begin
            for (int off = 0; off < NUM_PORTS; off++) begin
                pos = base + off;
                if (pos >= NUM_PORTS) begin
                    pos = pos - NUM_PORTS;
                end
                for (int i = 0; i < NUM_PORTS; i++) begin
                    if (!grant_valid && (i == pos) && req[i]) begin
                        grant[i]    = 1'b1;
                        grant_idx   = IDX_W'(i);
                        grant_valid = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if ((ARB_MODE == ARB_RR) && grant_valid) begin
            ptr_d = (int'(grant_idx) == NUM_PORTS - 1) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/vgpr_nto1_rd_port_arb.sv
// N-requester arbiter in front of a single VGPR bank read port.
// Grants one requester per cycle, registers its address to the bank, carries
// the requester index alongside the bank latency and steers the returned row
// back with a one-hot valid pulse RD_LATENCY+2 cycles after acceptance.
//   clk, rst      : clock, synchronous active-high reset
//   port_rd_en    : per-port request, held until accepted
//   port_rd_addr  : packed per-port addresses, port i at [i*ADDRWIDTH +: ADDRWIDTH]
//   port_rd_ready : combinational one-hot acceptance
//   port_rd_data  : registered return data shared by all ports
//   port_rd_valid : one-hot, one-cycle return pulse
//   rd_en/rd_addr : registered bank read request
//   rd_data       : bank data, valid RD_LATENCY cycles after rd_en
module vgpr_nto1_rd_port_arb
    import vgpr_rd_arb_pkg::*;
#(
    parameter int NUM_PORTS  = DEF_NUM_PORTS,
    parameter int ADDRWIDTH  = DEF_ADDRWIDTH,
    parameter int DATAWIDTH  = DEF_DATAWIDTH,
    parameter int RD_LATENCY = DEF_RD_LATENCY,
    parameter int ARB_MODE   = ARB_RR
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_PORTS-1:0]           port_rd_en,
    input  logic [NUM_PORTS*ADDRWIDTH-1:0] port_rd_addr,
    output logic [NUM_PORTS-1:0]           port_rd_ready,
    output logic [DATAWIDTH-1:0]           port_rd_data,
    output logic [NUM_PORTS-1:0]           port_rd_valid,
    output logic                           rd_en,
    output logic [ADDRWIDTH-1:0]           rd_addr,
    input  logic [DATAWIDTH-1:0]           rd_data
);

    localparam int IDX_W = port_idx_w(NUM_PORTS);

    logic [IDX_W-1:0]      grant_idx;
    logic                  grant_valid;
    logic [IDX_W-1:0]      issue_idx;
    logic [ADDRWIDTH-1:0]  addr_sel;
    logic [RD_LATENCY-1:0] tag_v;
    logic [IDX_W-1:0]      tag_idx [RD_LATENCY];
    logic [NUM_PORTS-1:0]  valid_d;

    vgpr_rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .ARB_MODE  (ARB_MODE)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .req         (port_rd_en),
        .grant       (port_rd_ready),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // Grant is one-hot, so an OR-reduction of masked addresses is a mux.
    always_comb begin
        addr_sel = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (port_rd_ready[i]) begin
                addr_sel = addr_sel | port_rd_addr[i*ADDRWIDTH +: ADDRWIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            issue_idx <= '0;
        end else begin
            rd_en <= grant_valid;
            if (grant_valid) begin
                rd_addr   <= addr_sel;
                issue_idx <= grant_idx;
            end
        end
    end

    // Stage 0 follows rd_en by one cycle, so the last stage lines up with
    // the cycle in which rd_data is valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_v <= '0;
            for (int k = 0; k < RD_LATENCY; k++) begin
                tag_idx[k] <= '0;
            end
        end else begin
            tag_v[0]   <= rd_en;
            tag_idx[0] <= issue_idx;
            for (int k = 1; k < RD_LATENCY; k++) begin
                tag_v[k]   <= tag_v[k-1];
                tag_idx[k] <= tag_idx[k-1];
            end
        end
    end

    always_comb begin
        valid_d = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            valid_d[i] = tag_v[RD_LATENCY-1] && (tag_idx[RD_LATENCY-1] == IDX_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            port_rd_valid <= '0;
            port_rd_data  <= '0;
        end else begin
            port_rd_valid <= valid_d;
            if (tag_v[RD_LATENCY-1]) begin
                port_rd_data <= rd_data;
            end
        end
    end

endmodule

// File: tb/tb_vgpr_nto1_rd_port_arb.sv
module tb_vgpr_nto1_rd_port_arb;
    localparam int NP = 4;
    localparam int AW = 10;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    // Round-robin, latency 1
    logic [NP-1:0]    a_en, a_ready, a_valid;
    logic [NP*AW-1:0] a_addr;
    logic [DW-1:0]    a_pdata, a_bdata;
    logic             a_rden;
    logic [AW-1:0]    a_rdaddr;
    // Fixed priority, latency 1
    logic [NP-1:0]    f_en, f_ready, f_valid;
    logic [NP*AW-1:0] f_addr;
    logic [DW-1:0]    f_pdata, f_bdata;
    logic             f_rden;
    logic [AW-1:0]    f_rdaddr;
    // Round-robin, latency 4
    logic [NP-1:0]    l_en, l_ready, l_valid;
    logic [NP*AW-1:0] l_addr;
    logic [DW-1:0]    l_pdata, l_bdata;
    logic             l_rden;
    logic [AW-1:0]    l_rdaddr;
    logic [DW-1:0]    l_pipe [4];

    vgpr_nto1_rd_port_arb #(.NUM_PORTS(NP), .ADDRWIDTH(AW), .DATAWIDTH(DW),
                            .RD_LATENCY(1), .ARB_MODE(0)) u_rr (
        .clk(clk), .rst(rst), .port_rd_en(a_en), .port_rd_addr(a_addr),
        .port_rd_ready(a_ready), .port_rd_data(a_pdata), .port_rd_valid(a_valid),
        .rd_en(a_rden), .rd_addr(a_rdaddr), .rd_data(a_bdata));

    vgpr_nto1_rd_port_arb #(.NUM_PORTS(NP), .ADDRWIDTH(AW), .DATAWIDTH(DW),
                            .RD_LATENCY(1), .ARB_MODE(1)) u_fx (
        .clk(clk), .rst(rst), .port_rd_en(f_en), .port_rd_addr(f_addr),
        .port_rd_ready(f_ready), .port_rd_data(f_pdata), .port_rd_valid(f_valid),
        .rd_en(f_rden), .rd_addr(f_rdaddr), .rd_data(f_bdata));

    vgpr_nto1_rd_port_arb #(.NUM_PORTS(NP), .ADDRWIDTH(AW), .DATAWIDTH(DW),
                            .RD_LATENCY(4), .ARB_MODE(0)) u_l4 (
        .clk(clk), .rst(rst), .port_rd_en(l_en), .port_rd_addr(l_addr),
        .port_rd_ready(l_ready), .port_rd_data(l_pdata), .port_rd_valid(l_valid),
        .rd_en(l_rden), .rd_addr(l_rdaddr), .rd_data(l_bdata));

    function automatic logic [DW-1:0] row(input logic [AW-1:0] a);
        return 32'hDA7A_0000 | {22'h0, a};
    endfunction

    // Bank models: address-tagged rows, garbage when not reading
    always @(posedge clk) a_bdata <= a_rden ? row(a_rdaddr) : 32'hDEAD_0000;
    always @(posedge clk) f_bdata <= f_rden ? row(f_rdaddr) : 32'hDEAD_0000;
    always @(posedge clk) begin
        l_pipe[0] <= l_rden ? row(l_rdaddr) : 32'hDEAD_0000;
        for (int k = 1; k < 4; k++) l_pipe[k] <= l_pipe[k-1];
    end
    assign l_bdata = l_pipe[3];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [AW-1:0] ad [4];
    logic [3:0]    e_r, e_v;
    int            j;

    initial begin
        ad[0] = 10'h010; ad[1] = 10'h020; ad[2] = 10'h030; ad[3] = 10'h040;
        a_addr = {ad[3], ad[2], ad[1], ad[0]};
        a_en = 4'hF;
        f_en = '0; f_addr = {10'h040, 10'h030, 10'h020, 10'h010};
        l_en = '0; l_addr = {10'h000, 10'h000, 10'h200, 10'h100};

        // Reset state, grant blocked while in reset
        tick(); tick();
        chk("rst_rd_en", a_rden, 0);
        chk("rst_rd_addr", a_rdaddr, 0);
        chk("rst_valid", a_valid, 0);
        chk("rst_data", a_pdata, 0);
        chk("rst_ready", a_ready, 0);
        rst = 1'b0;

        // Round-robin rotation with continuous requests (grants at k=0..6)
        for (int k = 0; k <= 10; k++) begin
            a_en = (k <= 6) ? 4'hF : 4'h0;
            #1;
            e_r = (k <= 6) ? 4'(1 << (k % 4)) : 4'h0;
            e_v = (k >= 3 && k <= 9) ? 4'(1 << ((k - 3) % 4)) : 4'h0;
            chk($sformatf("rr_ready_k%0d", k), a_ready, e_r);
            chk($sformatf("rr_rd_en_k%0d", k), a_rden, (k >= 1 && k <= 7));
            if (k >= 1) begin
                j = ((k > 7 ? 7 : k) - 1) % 4;
                chk($sformatf("rr_rd_addr_k%0d", k), a_rdaddr, ad[j]);
            end
            chk($sformatf("rr_valid_k%0d", k), a_valid, e_v);
            if (k >= 3) begin
                j = ((k > 9 ? 9 : k) - 3) % 4;
                chk($sformatf("rr_data_k%0d", k), a_pdata, row(ad[j]));
            end
            tick();
        end

        // Lone requester (port 2) while pointer sits at 3
        a_addr[2*AW +: AW] = 10'h3FF;
        a_en = 4'b0100;
        #1 chk("solo_ready", a_ready, 4'b0100);
        tick();
        a_en = 4'b0000;
        #1;
        chk("solo_rd_en", a_rden, 1);
        chk("solo_rd_addr", a_rdaddr, 10'h3FF);
        tick(); tick();
        chk("solo_valid", a_valid, 4'b0100);
        chk("solo_data", a_pdata, row(10'h3FF));

        // Idle: everything holds, nothing issues
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("idle_rd_en_%0d", i), a_rden, 0);
            chk($sformatf("idle_rd_addr_%0d", i), a_rdaddr, 10'h3FF);
            chk($sformatf("idle_valid_%0d", i), a_valid, 0);
            chk($sformatf("idle_data_%0d", i), a_pdata, row(10'h3FF));
        end

        // Pointer held at 3 through idle, then wraps to 0
        a_en = 4'b1001;
        #1 chk("wrap_ready0", a_ready, 4'b1000);
        tick();
        #1;
        chk("wrap_ready1", a_ready, 4'b0001);
        chk("wrap_rd_addr0", a_rdaddr, 10'h040);
        tick();
        a_en = 4'b0000;
        #1 chk("wrap_rd_addr1", a_rdaddr, 10'h010);
        tick(); tick(); tick();

        // Reset with two reads in flight (pointer is 1 before this)
        a_en = 4'b0110;
        #1 chk("mid_ready0", a_ready, 4'b0010);
        tick();
        #1 chk("mid_ready1", a_ready, 4'b0100);
        tick();
        a_en = 4'b0000;
        rst = 1'b1;
        #1 chk("mid_inflight", a_rden, 1);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("mid_valid_%0d", i), a_valid, 0);
            chk($sformatf("mid_rd_en_%0d", i), a_rden, 0);
            tick();
        end
        a_en = 4'b1010;
        #1 chk("post_rst_ready", a_ready, 4'b0010);
        tick();
        a_en = 4'b0000;
        #1 chk("post_rst_rd_addr", a_rdaddr, 10'h020);
        tick(); tick();
        chk("post_rst_valid", a_valid, 4'b0010);
        chk("post_rst_data", a_pdata, row(10'h020));

        // Fixed priority: port 1 starves port 3
        for (int i = 0; i < 4; i++) begin
            f_en = 4'b1010;
            #1 chk($sformatf("fx_ready_%0d", i), f_ready, 4'b0010);
            if (i >= 1) chk($sformatf("fx_rd_addr_%0d", i), f_rdaddr, 10'h020);
            if (i >= 3) begin
                chk("fx_valid", f_valid, 4'b0010);
                chk("fx_data", f_pdata, row(10'h020));
            end
            tick();
        end
        f_en = 4'b1000;
        #1 chk("fx_drop_ready", f_ready, 4'b1000);
        tick();
        f_en = 4'b0000;
        #1 chk("fx_p3_rd_addr", f_rdaddr, 10'h040);
        tick(); tick();
        chk("fx_p3_valid", f_valid, 4'b1000);
        chk("fx_p3_data", f_pdata, row(10'h040));

        // Latency 4: grants 0,1,0 return at +6 in order
        l_en = 4'b0011;
        #1 chk("l4_ready0", l_ready, 4'b0001);
        tick();
        #1 chk("l4_ready1", l_ready, 4'b0010);
        tick();
        l_en = 4'b0001;
        #1 chk("l4_ready2", l_ready, 4'b0001);
        tick();
        l_en = 4'b0000;
        for (int t = 4; t <= 9; t++) begin
            tick();
            case (t)
                6: begin
                    chk("l4_valid6", l_valid, 4'b0001);
                    chk("l4_data6", l_pdata, row(10'h100));
                end
                7: begin
                    chk("l4_valid7", l_valid, 4'b0010);
                    chk("l4_data7", l_pdata, row(10'h200));
                end
                8: begin
                    chk("l4_valid8", l_valid, 4'b0001);
                    chk("l4_data8", l_pdata, row(10'h100));
                end
                default: chk($sformatf("l4_valid%0d", t), l_valid, 0);
            endcase
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
